// File: rtl/acslip_ctrl_if.sv
// Slip handshake between the clock-slip controller and the RX FIFO.
// The controller drives the request and its direction; the FIFO answers with ack.
interface acslip_ctrl_if;
  logic slip_req;
  logic slip_dir;
  logic slip_ack;

  modport master (output slip_req, output slip_dir, input slip_ack);
  modport slave  (input slip_req, input slip_dir, output slip_ack);
endinterface

// File: rtl/acslip_ctrl.sv
// I2S RX clock-slip controller: tracks I2S vs reference tick drift and requests
// one sample drop/insert on the RX FIFO when the drift reaches the threshold.
//
// state | meaning
// IDLE  | disabled; drift and overflow held at 0, ticks ignored
// TRACK | accumulating drift, comparing against threshold each edge
// REQ   | slip request outstanding, waiting for FIFO ack
// HOLD  | post-slip holdoff, accumulating without comparing
module acslip_ctrl #(
  parameter int DRIFT_WIDTH = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   wbs_clk_i,
  input  logic                   acslip_rst,
  input  logic                   enable_i,
  input  logic                   i2s_tick_i,
  input  logic                   ref_tick_i,
  input  logic [DRIFT_WIDTH-1:0] thresh_i,
  input  logic [7:0]             holdoff_i,
  input  logic                   irq_clr_i,
  acslip_ctrl_if.master          fifo,
  output logic [DRIFT_WIDTH-1:0] drift_o,
  output logic [CNT_WIDTH-1:0]   ins_cnt_o,
  output logic [CNT_WIDTH-1:0]   drop_cnt_o,
  output logic                   slip_irq_o,
  output logic                   overflow_o
);

  // Two guard bits cover drift +/- an unsigned threshold plus one tick.
  localparam int EW = DRIFT_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, TRACK, REQ, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [DRIFT_WIDTH-1:0] drift_q, drift_d;
  logic [CNT_WIDTH-1:0]   ins_q, ins_d, drop_q, drop_d;
  logic [7:0]             hold_q, hold_d;
  logic                   dir_q, dir_d;
  logic                   ovf_q, ovf_d;
  logic                   irq_q, irq_d;
  logic                   irq_set;

  logic signed [EW-1:0]   drift_ext, thresh_ext, delta, base, sum;
  logic signed [EW-1:0]   drift_max, drift_min;
  logic [DRIFT_WIDTH-1:0] drift_sat;
  logic                   sat_hit;
  logic                   thr_on, hit_pos, hit_neg, ack_req;

  assign drift_max  = {3'b000, {(DRIFT_WIDTH-1){1'b1}}};
  assign drift_min  = {3'b111, {(DRIFT_WIDTH-1){1'b0}}};
  assign drift_ext  = {{2{drift_q[DRIFT_WIDTH-1]}}, drift_q};
  assign thresh_ext = {2'b00, thresh_i};

  assign thr_on  = (thresh_i != '0);
  assign hit_pos = thr_on && (drift_ext >= thresh_ext);
  assign hit_neg = thr_on && (drift_ext <= -thresh_ext);
  assign ack_req = (state_q == REQ) && fifo.slip_ack;

  always_comb begin
    delta = '0;
    if (i2s_tick_i && !ref_tick_i)
      delta = {{(EW-1){1'b0}}, 1'b1};
    else if (ref_tick_i && !i2s_tick_i)
      delta = '1;
  end

  // The ack cycle folds the threshold correction and the tick delta into one update.
  always_comb begin
    base = drift_ext;
    if (ack_req)
      base = dir_q ? (drift_ext - thresh_ext) : (drift_ext + thresh_ext);
    sum       = base + delta;
    drift_sat = sum[DRIFT_WIDTH-1:0];
    sat_hit   = 1'b0;
    if (sum > drift_max) begin
      drift_sat = drift_max[DRIFT_WIDTH-1:0];
      sat_hit   = 1'b1;
    end else if (sum < drift_min) begin
      drift_sat = drift_min[DRIFT_WIDTH-1:0];
      sat_hit   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    drift_d = drift_q;
    ovf_d   = ovf_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    ins_d   = ins_q;
    drop_d  = drop_q;
    irq_set = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      drift_d = '0;
      ovf_d   = 1'b0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = TRACK;
          drift_d = '0;
          ovf_d   = 1'b0;
        end
        TRACK: begin
          drift_d = drift_sat;
          ovf_d   = ovf_q | sat_hit;
          if (hit_pos) begin
            state_d = REQ;
            dir_d   = 1'b1;
          end else if (hit_neg) begin
            state_d = REQ;
            dir_d   = 1'b0;
          end
        end
        REQ: begin
          drift_d = drift_sat;
          ovf_d   = ovf_q | sat_hit;
          if (fifo.slip_ack) begin
            irq_set = 1'b1;
            if (dir_q)
              drop_d = drop_q + CNT_WIDTH'(1);
            else
              ins_d = ins_q + CNT_WIDTH'(1);
            if (holdoff_i == 8'd0) begin
              state_d = TRACK;
            end else begin
              state_d = HOLD;
              hold_d  = holdoff_i;
            end
          end
        end
        HOLD: begin
          drift_d = drift_sat;
          ovf_d   = ovf_q | sat_hit;
          if (hold_q <= 8'd1) begin
            state_d = TRACK;
            hold_d  = '0;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    irq_d = irq_set | (irq_q & ~irq_clr_i);
  end

  always_ff @(posedge wbs_clk_i or posedge acslip_rst) begin
    if (acslip_rst) begin
      state_q <= IDLE;
      drift_q <= '0;
      ovf_q   <= 1'b0;
      dir_q   <= 1'b0;
      hold_q  <= '0;
      ins_q   <= '0;
      drop_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drift_q <= drift_d;
      ovf_q   <= ovf_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      ins_q   <= ins_d;
      drop_q  <= drop_d;
      irq_q   <= irq_d;
    end
  end

  // Request decodes straight from the state register so reset drops it at once.
  assign fifo.slip_req = (state_q == REQ);
  assign fifo.slip_dir = dir_q;
  assign drift_o       = drift_q;
  assign ins_cnt_o     = ins_q;
  assign drop_cnt_o    = drop_q;
  assign slip_irq_o    = irq_q;
  assign overflow_o    = ovf_q;

endmodule
